lsu_ctrl: RTL

Parametrised load/store unit for the RV32I core: sits between the execute stage and the data-memory port. Computes the effective address, steers byte/halfword/word data onto the correct byte lanes with byte enables, and sign/zero-extends loads. Runs a registered request/grant/response handshake with wait states, detects misaligned accesses and times out stalled transactions. A single outstanding access at a time.

---
 rtl/lsu_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit between execute and the data-memory port: effective address,
// lane steering with byte enables, load extension, and a timed request/grant/response handshake.
module lsu_ctrl #(
  parameter int ADDR_W        = 32,
  parameter int TIMEOUT       = 15,
  parameter int TRAP_MISALIGN = 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_op,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_offset,
  input  logic [31:0]       i_wdata,
  output logic              o_done,
  output logic [31:0]       o_wb_data,
  output logic              o_wb_en,
  output logic              o_misalign,
  output logic              o_timeout,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cntInc;
  logic [2:0]        op_q, op_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       wbData_q, wbData_d;
  logic              wbEn_q, wbEn_d;
  logic              misalign_q, misalign_d;
  logic              timeout_q, timeout_d;

  logic [ADDR_W-1:0] ea;
  logic              isHalf, isWord, misal, isStoreQ;
  logic [1:0]        reqLane;
  logic [3:0]        reqBe;
  logic [31:0]       reqWdata, loadVal;
  logic [7:0]        rByte;
  logic [15:0]       rHalf;

  assign ea       = i_base + i_offset;
  assign cntInc   = cnt_q + CNT_W'(1);
  assign isStoreQ = op_q[2] && (op_q[1:0] != 2'b00);

  // Request decode; the lane is pulled to natural alignment so the non-trapping build just proceeds.
  always_comb begin
    isHalf = 1'b0;
    isWord = 1'b0;
    case (i_op)
      3'd2, 3'd3, 3'd6: isHalf = 1'b1;
      3'd4, 3'd5:       isWord = 1'b1;
      default:          ;
    endcase
    misal    = (isHalf && ea[0]) || (isWord && (ea[1:0] != 2'b00));
    reqLane  = isWord ? 2'b00 : (isHalf ? {ea[1], 1'b0} : ea[1:0]);
    reqBe    = isWord ? 4'b1111 : (isHalf ? (4'b0011 << reqLane) : (4'b0001 << reqLane));
    reqWdata = isWord ? i_wdata : (isHalf ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}});
  end

  always_comb begin
    rByte = i_mem_rdata[7:0];
    case (lane_q)
      2'd1:    rByte = i_mem_rdata[15:8];
      2'd2:    rByte = i_mem_rdata[23:16];
      2'd3:    rByte = i_mem_rdata[31:24];
      default: ;
    endcase
    rHalf = lane_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (op_q)
      3'd0:    loadVal = {{24{rByte[7]}}, rByte};
      3'd1:    loadVal = {24'h0, rByte};
      3'd2:    loadVal = {{16{rHalf[15]}}, rHalf};
      3'd3:    loadVal = {16'h0, rHalf};
      default: loadVal = i_mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    lane_d     = lane_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    wbData_d   = wbData_q;
    wbEn_d     = wbEn_q;
    misalign_d = misalign_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          op_d       = i_op;
          lane_d     = reqLane;
          addr_d     = {ea[ADDR_W-1:2], 2'b00};
          be_d       = reqBe;
          wdata_d    = reqWdata;
          cnt_d      = '0;
          wbData_d   = '0;
          wbEn_d     = 1'b0;
          misalign_d = 1'b0;
          timeout_d  = 1'b0;
          if (misal && (TRAP_MISALIGN != 0)) begin
            misalign_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      // The timeout wins over a grant or response arriving in the same cycle.
      REQ: begin
        cnt_d = cntInc;
        if (cntInc == TO_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else if (i_mem_gnt) begin
          state_d = isStoreQ ? DONE : RESP;
        end
      end
      RESP: begin
        cnt_d = cntInc;
        if (cntInc == TO_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else if (i_mem_rvalid) begin
          wbData_d = loadVal;
          wbEn_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= 3'd0;
      lane_q     <= 2'd0;
      addr_q     <= '0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      wbData_q   <= 32'd0;
      wbEn_q     <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      lane_q     <= lane_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      wbData_q   <= wbData_d;
      wbEn_q     <= wbEn_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_done      = (state_q == DONE);
  assign o_mem_req   = (state_q == REQ);
  assign o_mem_we    = isStoreQ;
  assign o_mem_addr  = addr_q;
  assign o_mem_be    = be_q;
  assign o_mem_wdata = wdata_q;
  assign o_wb_data   = wbData_q;
  assign o_wb_en     = o_done && wbEn_q;
  assign o_misalign  = o_done && misalign_q;
  assign o_timeout   = o_done && timeout_q;

endmodule
